// File: rtl/switch_bounce_emulator.sv
// Emulates a chattering mechanical contact: new level, N pseudo-random glitch pairs, then a settle hold.
// Latency: first edge appears 1 cycle after the level mismatch is sampled; done pulses on SETTLE exit.
// Backpressure: none; target_in changes are ignored while busy and re-evaluated once back in IDLE.
module switch_bounce_emulator #(
    parameter int unsigned INTV_W     = 8,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter logic        INIT_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              target_in,
    input  logic [3:0]        bounce_cnt,
    input  logic [INTV_W-1:0] interval_mask,
    input  logic [INTV_W-1:0] settle_time,
    output logic              noisy_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_POLY = 16'hB400;

    state_t            state_q;
    logic [15:0]       lfsr_q;
    logic [15:0]       lfsr_d;
    logic [INTV_W-1:0] cnt_q;
    logic [4:0]        toggles_q;
    logic [INTV_W-1:0] mask_q;
    logic [INTV_W-1:0] settle_q;
    logic              noisy_q;
    logic              busy_q;
    logic              done_q;

    // Interval candidates: current LFSR slice masked by the live mask (sequence start)
    // or by the mask latched at sequence start (reloads inside BOUNCE).
    logic [INTV_W-1:0] r_w;
    logic [INTV_W-1:0] start_gap_w;
    logic [INTV_W-1:0] bounce_gap_w;

    assign r_w          = lfsr_q[INTV_W-1:0];
    assign start_gap_w  = r_w & interval_mask;
    assign bounce_gap_w = r_w & mask_q;

    // Galois right-shift step; feedback taps applied when the bit shifted out is 1.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_POLY;
        end
    end

    // Free-running LFSR: advances every cycle out of reset, independent of the sequencer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Transition sequencer: IDLE -> BOUNCE (first edge + glitch pairs) -> SETTLE -> IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            toggles_q <= '0;
            mask_q    <= '0;
            settle_q  <= '0;
            noisy_q   <= INIT_LEVEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (target_in != noisy_q) begin
                        noisy_q   <= target_in;
                        mask_q    <= interval_mask;
                        settle_q  <= settle_time;
                        toggles_q <= {bounce_cnt, 1'b0};
                        cnt_q     <= start_gap_w;
                        busy_q    <= 1'b1;
                        state_q   <= BOUNCE;
                    end
                end
                BOUNCE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - INTV_W'(1);
                    end else if (toggles_q != 5'd0) begin
                        // Even toggle count guarantees the level is back on target at SETTLE entry.
                        noisy_q   <= ~noisy_q;
                        toggles_q <= toggles_q - 5'd1;
                        cnt_q     <= bounce_gap_w;
                    end else begin
                        cnt_q   <= settle_q;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - INTV_W'(1);
                    end else begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign noisy_out = noisy_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_switch_bounce_emulator.sv
// Bench for switch_bounce_emulator: table of hand-derived sequences, corner cases, and
// randomized sequences checked every cycle against a schedule-based reference model.
// The model predicts a whole sequence's waveform up front from the LFSR value at its start edge.
module tb_switch_bounce_emulator;

    localparam int          W    = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic         clk = 1'b0;
    logic         reset;
    logic         target_in;
    logic [3:0]   bounce_cnt;
    logic [W-1:0] interval_mask;
    logic [W-1:0] settle_time;
    logic         noisy_out;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    switch_bounce_emulator #(
        .INTV_W     (W),
        .SEED       (SEED),
        .INIT_LEVEL (1'b0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .target_in     (target_in),
        .bounce_cnt    (bounce_cnt),
        .interval_mask (interval_mask),
        .settle_time   (settle_time),
        .noisy_out     (noisy_out),
        .busy          (busy),
        .done          (done)
    );

    typedef struct packed {
        logic noisy;
        logic bsy;
        logic dn;
    } obs_t;

    typedef struct {
        logic         tgt;
        logic [3:0]   bc;
        logic [W-1:0] mask;
        logic [W-1:0] st;
        int           exp_done;   // edge offset of done after T, -1 = not hand-computed
        int           exp_edges;  // output transitions in the sequence
    } vec_t;

    obs_t        exp_q[$];
    logic [15:0] ref_lfsr;
    logic        mdl_level;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int k);
        logic [15:0] x;
        x = v;
        for (int i = 0; i < k; i++) x = lfsr_step(x);
        return x;
    endfunction

    // Build the expected per-edge outputs of a whole sequence starting at edge T (offset 0).
    function automatic void plan(input logic tgt, input logic [3:0] bc, input logic [W-1:0] m,
                                 input logic [W-1:0] st, input logic [15:0] v0);
        int           toggle_at[$];
        int           t;
        int           g;
        int           d;
        int           ntog;
        logic [15:0]  v;
        logic [W-1:0] r;
        logic         lvl;
        t    = 0;
        v    = v0;
        ntog = 2 * int'(bc);
        for (int k = 0; k <= ntog; k++) begin
            r = v[W-1:0];
            g = int'(r & m) + 1;
            t = t + g;
            v = lfsr_adv(v, g);
            if (k < ntog) toggle_at.push_back(t);
        end
        d   = t + int'(st) + 1;
        lvl = tgt;
        for (int j = 0; j <= d; j++) begin
            if (toggle_at.size() != 0 && toggle_at[0] == j) begin
                lvl = ~lvl;
                void'(toggle_at.pop_front());
            end
            exp_q.push_back(obs_t'{lvl, (j < d), (j == d)});
        end
        mdl_level = tgt;
    endfunction

    // Cycle monitor: every clock out of reset, compare outputs to the model's schedule.
    always @(posedge clk) begin
        obs_t e;
        if (!reset) begin
            if (exp_q.size() == 0 && target_in !== mdl_level)
                plan(target_in, bounce_cnt, interval_mask, settle_time, ref_lfsr);
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else                   e = obs_t'{mdl_level, 1'b0, 1'b0};
            ref_lfsr = lfsr_step(ref_lfsr);
            #1;
            n_vec++;
            if ({noisy_out, busy, done} !== e) begin
                n_err++;
                $display("FAIL cycle_model t=%0t: noisy/busy/done got %b%b%b, expected %b%b%b",
                         $time, noisy_out, busy, done, e.noisy, e.bsy, e.dn);
            end
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s t=%0t: got %0d, expected %0d", name, $time, got, expv);
        end
    endtask

    task automatic wait_done(input string name, input bit scramble);
        int j;
        bit seen;
        j    = 0;
        seen = 1'b0;
        while (!seen && j < 5000) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            j++;
            if (scramble && !seen) begin
                bounce_cnt    = 4'($urandom);
                interval_mask = W'($urandom);
                settle_time   = W'($urandom);
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: done not seen within 5000 cycles", name);
        end
    endtask

    // Drive a table record at a negedge and measure the resulting sequence.
    task automatic run_vec(input vec_t v, input int idx);
        int   j;
        int   edges;
        int   gap;
        int   gap_max;
        bit   seen;
        logic prev;
        bounce_cnt    = v.bc;
        interval_mask = v.mask;
        settle_time   = v.st;
        target_in     = v.tgt;
        prev    = noisy_out;
        j       = 0;
        edges   = 0;
        gap     = 0;
        gap_max = 0;
        seen    = 1'b0;
        while (!seen && j < 5000) begin
            @(negedge clk);
            gap++;
            if (noisy_out !== prev) begin
                if (edges > 0 && gap > gap_max) gap_max = gap;
                edges++;
                gap = 0;
            end
            prev = noisy_out;
            if (done === 1'b1) seen = 1'b1;
            else j++;
        end
        chk($sformatf("tbl%0d_done_seen", idx), int'(seen), 1);
        if (v.exp_done >= 0) chk($sformatf("tbl%0d_done_edge", idx), j, v.exp_done);
        chk($sformatf("tbl%0d_edges", idx), edges, v.exp_edges);
        chk($sformatf("tbl%0d_final_level", idx), int'(noisy_out), int'(v.tgt));
        chk($sformatf("tbl%0d_gap_in_range", idx), int'(gap_max <= int'(v.mask) + 1), 1);
    endtask

    task automatic model_reset();
        exp_q.delete();
        ref_lfsr  = SEED;
        mdl_level = 1'b0;
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b1, 4'd2,  8'h00, 8'd3, 9,  5};
        tbl[1] = '{1'b0, 4'd0,  8'h00, 8'd0, 2,  1};
        tbl[2] = '{1'b1, 4'd1,  8'h00, 8'd5, 9,  3};
        tbl[3] = '{1'b0, 4'd3,  8'h00, 8'd1, 9,  7};
        tbl[4] = '{1'b1, 4'd15, 8'h00, 8'd0, 32, 31};
        tbl[5] = '{1'b0, 4'd15, 8'h0F, 8'd2, -1, 31};

        reset         = 1'b1;
        target_in     = 1'b0;
        bounce_cnt    = 4'd0;
        interval_mask = '0;
        settle_time   = '0;
        model_reset();

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_noisy", int'(noisy_out), 0);
        chk("reset_busy",  int'(busy), 0);
        chk("reset_done",  int'(done), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_hold_busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

        // Retarget during BOUNCE: completes to latched level, then restarts toward new target.
        bounce_cnt    = 4'd4;
        interval_mask = 8'h03;
        settle_time   = 8'd2;
        target_in     = 1'b1;
        repeat (3) @(negedge clk);
        target_in = 1'b0;
        wait_done("retarget_first", 1'b0);
        chk("retarget_level_at_done", int'(noisy_out), 1);
        @(negedge clk);
        chk("retarget_restart_busy",  int'(busy), 1);
        chk("retarget_restart_level", int'(noisy_out), 0);
        wait_done("retarget_second", 1'b0);

        // Reset mid-BOUNCE: asynchronous abort, no done, LFSR back to SEED.
        bounce_cnt    = 4'd6;
        interval_mask = 8'h07;
        settle_time   = 8'd4;
        target_in     = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_abort_busy", int'(busy), 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("abort_noisy_async", int'(noisy_out), 0);
        chk("abort_busy_async",  int'(busy), 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", int'(done), 0);
        end
        reset = 1'b0;
        wait_done("rerun_after_abort", 1'b0);

        // Randomized sequences; config scrambled while busy to exercise latching.
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            bounce_cnt    = 4'($urandom_range(0, 15));
            interval_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : W'($urandom_range(0, 15));
            settle_time   = W'($urandom_range(0, 20));
            target_in     = ~noisy_out;
            wait_done($sformatf("rand%0d", n), 1'b1);
        end
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
